// File: rtl/life_run_controller.sv
// life_run_controller
// Sequencer for the 4x4 Life array. On start it loads a seed pattern through
// the array's write port. It then issues single-generation step pulses every
// TICK_DIV clocks and stops on extinction, still life, period-2 oscillation or
// the generation limit.
// Optional feature: define LIFE_CTRL_PERIOD2_DETECT_EN to add the history
// register and the period-2 (code 11) stop condition.
module life_run_controller #(
    parameter int TICK_DIV = 4,
    parameter int GEN_W    = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [15:0]      pattern,
    input  logic [GEN_W-1:0] gen_limit,
    input  logic [15:0]      alive,
    input  logic [15:0]      alive_prev,
    output logic [15:0]      val,
    output logic             write_enb,
    output logic             step,
    output logic             busy,
    output logic             done,
    output logic [1:0]       done_code,
    output logic [GEN_W-1:0] gen_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_GAP,
        S_STEP,
        S_CHECK,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [1:0] CODE_LIMIT   = 2'b00;
    localparam logic [1:0] CODE_EXTINCT = 2'b01;
    localparam logic [1:0] CODE_STILL   = 2'b10;
    localparam logic [1:0] CODE_PERIOD2 = 2'b11;

    // Last WAIT count value. WAIT lasts TICK_DIV-2 cycles, so STEP-to-STEP
    // spacing is STEP + CHECK + WAIT = TICK_DIV. This value is unused when
    // TICK_DIV is 2.
    localparam logic [7:0] WAIT_LAST = 8'(TICK_DIV - 3);

    state_t           state;
    logic [GEN_W-1:0] limit_q;
    logic [7:0]       wait_cnt;
    logic             run_state;
    logic             limit_hit;
    logic             p2_hit;
    logic             stop_hit;
    logic [1:0]       stop_code;

    // The generation counter sticks at all-ones instead of wrapping.
    function automatic logic [GEN_W-1:0] sat_inc(input logic [GEN_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign run_state = (state != S_IDLE) && (state != S_DONE);
    assign limit_hit = (limit_q != '0) && (gen_count == limit_q);

`ifdef LIFE_CTRL_PERIOD2_DETECT_EN
    logic [15:0] history;

    // Remember the generation before the previous one, captured at each CHECK.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            history <= '0;
        end else if (state == S_CHECK) begin
            history <= alive_prev;
        end
    end

    // History is only meaningful once two generations have been stepped.
    assign p2_hit = (alive == history) && (gen_count >= GEN_W'(2));
`else
    assign p2_hit = 1'b0;
`endif

    // Stop-condition evaluation in priority order; used only in CHECK.
    always_comb begin
        stop_hit  = 1'b1;
        stop_code = CODE_LIMIT;
        if (alive == 16'h0000) begin
            stop_code = CODE_EXTINCT;
        end else if (alive == alive_prev) begin
            stop_code = CODE_STILL;
        end else if (p2_hit) begin
            stop_code = CODE_PERIOD2;
        end else if (limit_hit) begin
            stop_code = CODE_LIMIT;
        end else begin
            stop_hit = 1'b0;
        end
    end

    // Run FSM. Strobes are registered and set on entry to the state that owns them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            val       <= '0;
            limit_q   <= '0;
            wait_cnt  <= '0;
            write_enb <= 1'b0;
            step      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            done_code <= CODE_LIMIT;
            gen_count <= '0;
        end else if (abort && run_state) begin
            // Abort drops straight to IDLE: no done pulse, result registers untouched.
            state     <= S_IDLE;
            write_enb <= 1'b0;
            step      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        val       <= pattern;
                        limit_q   <= gen_limit;
                        gen_count <= '0;
                        write_enb <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    write_enb <= 1'b0;
                    state     <= S_GAP;
                end
                S_GAP: begin
                    step  <= 1'b1;
                    state <= S_STEP;
                end
                S_STEP: begin
                    step      <= 1'b0;
                    gen_count <= sat_inc(gen_count);
                    state     <= S_CHECK;
                end
                S_CHECK: begin
                    if (stop_hit) begin
                        done_code <= stop_code;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_DONE;
                    end else if (TICK_DIV == 2) begin
                        step  <= 1'b1;
                        state <= S_STEP;
                    end else begin
                        wait_cnt <= '0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        step  <= 1'b1;
                        state <= S_STEP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_life_run_controller.sv
// Bench for life_run_controller with a behavioural 4x4 Life array (dead edges).
`timescale 1ns/1ps
module tb_life_run_controller;

    localparam int TICK_DIV = 4;
    localparam int GEN_W    = 8;

`ifdef LIFE_CTRL_PERIOD2_DETECT_EN
    localparam logic [1:0] OSC_CODE   = 2'b11;
    localparam int         BLINK_GEN  = 2;
    localparam int         TOAD_GEN   = 2;
    localparam int         ABORT_GEN  = 1;
`else
    localparam logic [1:0] OSC_CODE   = 2'b00;
    localparam int         BLINK_GEN  = 6;
    localparam int         TOAD_GEN   = 4;
    localparam int         ABORT_GEN  = 3;
`endif

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [15:0]      pattern = '0;
    logic [GEN_W-1:0] gen_limit = '0;
    logic [15:0]      alive;
    logic [15:0]      alive_prev;
    logic [15:0]      val;
    logic             write_enb;
    logic             step;
    logic             busy;
    logic             done;
    logic [1:0]       done_code;
    logic [GEN_W-1:0] gen_count;

    typedef struct packed {
        logic [1:0]  code;
        logic [7:0]  gen;
        logic [15:0] alive;
    } exp_t;

    exp_t sb_q[$];
    int   step_cyc[$];
    logic [15:0] alive_log[$];
    int   cyc = 0;
    int   wr_cnt = 0;
    int   done_cnt = 0;
    int   overlap = 0;
    logic prev_pulse = 1'b0;
    logic prev_step = 1'b0;
    int   n_total = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    life_run_controller #(.TICK_DIV(TICK_DIV), .GEN_W(GEN_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .pattern(pattern), .gen_limit(gen_limit),
        .alive(alive), .alive_prev(alive_prev),
        .val(val), .write_enb(write_enb), .step(step), .busy(busy),
        .done(done), .done_code(done_code), .gen_count(gen_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] life_next(input logic [15:0] s);
        logic [15:0] n;
        int cnt;
        n = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < 4 &&
                            c + dc >= 0 && c + dc < 4 && s[(r + dr) * 4 + c + dc])
                            cnt++;
                n[r * 4 + c] = s[r * 4 + c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
            end
        end
        return n;
    endfunction

    // Behavioural Life array: write loads the pattern, step advances one generation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alive      <= '0;
            alive_prev <= '0;
        end else if (write_enb) begin
            alive      <= val;
            alive_prev <= '0;
        end else if (step) begin
            alive_prev <= alive;
            alive      <= life_next(alive);
        end
    end

    // Pulse monitor: step timing, write count, pulse separation, post-step array state.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (step) step_cyc.push_back(cyc);
        if (write_enb) wr_cnt <= wr_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if ((step && write_enb) || ((step || write_enb) && prev_pulse)) overlap <= overlap + 1;
        prev_pulse <= step || write_enb;
        if (prev_step) alive_log.push_back(alive);
        prev_step <= step;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_val"},  32'(val), 32'h0);
        check({tag, "_strb"}, 32'({write_enb, step, busy, done}), 32'h0);
        check({tag, "_res"},  32'({done_code, gen_count}), 32'h0);
    endtask

    task automatic do_run(input string tag, input logic [15:0] p, input logic [7:0] lim,
                          input logic [1:0] e_code, input logic [7:0] e_gen,
                          input logic [15:0] e_alive);
        exp_t e;
        bit   seen;
        sb_q.push_back('{code: e_code, gen: e_gen, alive: e_alive});
        @(negedge clk);
        pattern   = p;
        gen_limit = lim;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_load"}, 32'({write_enb, step, busy}), 32'b101);
        check({tag, "_val"}, 32'(val), 32'(p));
        @(negedge clk);
        check({tag, "_gap"}, 32'({write_enb, step, busy}), 32'b001);
        @(negedge clk);
        check({tag, "_step1"}, 32'({write_enb, step, busy}), 32'b011);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'h1);
        if (seen) begin
            e = sb_q.pop_front();
            check({tag, "_code"}, 32'(done_code), 32'(e.code));
            check({tag, "_gen"}, 32'(gen_count), 32'(e.gen));
            check({tag, "_alive"}, 32'(alive), 32'(e.alive));
            check({tag, "_busy_at_done"}, 32'(busy), 32'h0);
            @(negedge clk);
            check({tag, "_hold"}, 32'({done, done_code, gen_count}), 32'({1'b0, e.code, e.gen}));
        end else begin
            void'(sb_q.pop_front());
        end
    endtask

    initial begin
        int wr_base;
        int steps_seen;
        int step_base;
        int done_base;
        logic [1:0] code_before;

        // Reset state
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs_zero("idle");

        // Still life, extinction, blinker
        do_run("still", 16'h0660, 8'd5, 2'b10, 8'd1, 16'h0660);
        do_run("extinct", 16'h0001, 8'd0, 2'b01, 8'd1, 16'h0000);
        do_run("blinker", 16'h0070, 8'd6, OSC_CODE, 8'(BLINK_GEN), 16'h0070);

        // Toad: pulse spacing and array alternation
        @(negedge clk);
        step_cyc.delete();
        alive_log.delete();
        wr_base = wr_cnt;
        do_run("toad", 16'h6186, 8'd4, OSC_CODE, 8'(TOAD_GEN), 16'h6186);
        repeat (2) @(negedge clk);
        check("toad_write_count", 32'(wr_cnt - wr_base), 32'h1);
        check("toad_step_count", 32'(step_cyc.size()), 32'(TOAD_GEN));
        for (int i = 1; i < step_cyc.size(); i++)
            check("toad_step_spacing", 32'(step_cyc[i] - step_cyc[i - 1]), 32'(TICK_DIV));
        for (int i = 0; i < alive_log.size(); i++)
            check("toad_alive_alt", 32'(alive_log[i]), (i % 2 == 0) ? 32'h2664 : 32'h6186);
        check("pulse_overlap", 32'(overlap), 32'h0);

        // Abort beats start in IDLE
        start = 1'b1;
        abort = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_beats_start", 32'({write_enb, busy}), 32'h0);
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);

        // Abort one cycle into WAIT
        code_before = done_code;
        pattern     = 16'h0070;
        gen_limit   = 8'd0;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        steps_seen = 0;
        for (int i = 0; i < 100 && steps_seen < ABORT_GEN; i++) begin
            @(negedge clk);
            if (step) steps_seen++;
        end
        check("abort_reached_gen", 32'(steps_seen), 32'(ABORT_GEN));
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy_low", 32'({busy, step, done}), 32'h0);
        step_base = step_cyc.size();
        done_base = done_cnt;
        repeat (10) @(negedge clk);
        #1;
        check("abort_no_step", 32'(step_cyc.size() - step_base), 32'h0);
        check("abort_no_done", 32'(done_cnt - done_base), 32'h0);
        check("abort_code_kept", 32'(done_code), 32'(code_before));
        check("abort_gen_count", 32'(gen_count), 32'(ABORT_GEN));

        // Asynchronous reset mid-run
        @(negedge clk);
        pattern   = 16'h6186;
        gen_limit = 8'd0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/life_run_controller.md
# life_run_controller

Sequencer for the 4x4 Life array: on a start request it loads a seed pattern through the array's write port, then issues single-generation step pulses at a programmable rate. After each generation it inspects `alive`/`alive_prev` and stops on extinction, still life, period-2 oscillation or a generation limit. It sits between the top-level control (buttons/host) and `life_array_4x4`, and owns that array's `val`, `write_enb` and `step` inputs.

## Interface
- `TICK_DIV`, default 4: clocks per generation, STEP through the end of WAIT; legal range 2..255.
- `GEN_W`, default 8: width of the generation limit and counter.

- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `start`  in  1  level; sampled in IDLE only.
- `abort`  in  1  level; stops a run from any busy state.
- `pattern`  in  16  seed pattern; captured when `start` is accepted.
- `gen_limit`  in  GEN_W  maximum number of generations; 0 means unlimited. Captured with `pattern`.
- `alive`  in  16  current array state.
- `alive_prev`  in  16  array state one generation earlier.
- `val`  out  16  write data to the array; holds the captured pattern.
- `write_enb`  out  1  one-cycle array write pulse.
- `step`  out  1  one-cycle array step pulse.
- `busy`  out  1  high from LOAD through WAIT.
- `done`  out  1  one-cycle pulse when a run ends.
- `done_code`  out  2  run result: 00 limit, 01 extinct, 10 still life, 11 period-2.
- `gen_count`  out  GEN_W  number of generations stepped in the current or last run.

## Operation
- FSM states: IDLE, LOAD, GAP, STEP, CHECK, WAIT, DONE.
- **IDLE**: when `start`=1, capture `pattern` and `gen_limit`, clear `gen_count`, go to LOAD.
- **LOAD**: drive `write_enb`=1, go to GAP.
- **GAP**: all strobes low, go to STEP.
- **STEP**: drive `step`=1, increment `gen_count` (saturates at all-ones), go to CHECK.
- **CHECK**: `alive` now holds the new generation. Evaluate the stop conditions in this priority order:
  - `alive`==0 → code 01.
  - `alive`==`alive_prev` → code 10.
  - Period-2 match (see Configuration) → code 11.
  - `gen_limit`≠0 and `gen_count`==`gen_limit` → code 00.
  - On any hit, latch `done_code` and go to DONE. Otherwise go to WAIT, or straight to STEP if `TICK_DIV`==2.
- **WAIT**: stay for `TICK_DIV`-2 cycles (counter), then go to STEP.
- **DONE**: `done`=1 for one cycle, then go to IDLE. `gen_count` and `done_code` hold until the next accepted start.
- **Abort**: `abort`=1 in LOAD, GAP, STEP, CHECK or WAIT → IDLE on the next edge. No `done` pulse; `done_code` is unchanged. `abort` beats `start` if both are high in IDLE (start is ignored).
- `start` held high through DONE begins a new run after one IDLE cycle.
- `step` and `write_enb` are never high together, and are never high on consecutive cycles, because the array acts on each pulse.

## Timing
- Reset values: FSM=IDLE, `val`=0, `write_enb`=0, `step`=0, `busy`=0, `done`=0, `done_code`=00, `gen_count`=0, internal history=0.
- Reset asserted mid-run forces the reset values immediately (asynchronous). Outputs go low without waiting for the current pulse to finish.
- Run timeline, with `start` sampled at edge E0:
  - LOAD during E0–E1 (`write_enb`=1).
  - GAP during E1–E2.
  - First STEP during E2–E3.
  - CHECK during E3–E4.
- Each subsequent STEP follows the previous one by exactly `TICK_DIV` cycles.
- `done` is asserted in the cycle after the terminating CHECK. `busy` is low in that same cycle.
- All outputs are registered.

## Configuration
- Macro `LIFE_CTRL_PERIOD2_DETECT_EN`.
- **Defined**: a 16-bit register captures `alive_prev` at every CHECK. Period-2 match is `alive`==history with `gen_count`≥2, giving code 11.
- **Undefined**: no history register and code 11 is never produced. Oscillators run until `gen_limit`, or until abort if the limit is 0.

## Test plan
Bench: a real `life_array_4x4` with edge inputs tied to 0, `TICK_DIV`=4 unless stated.
- **Still life**: pattern 16'h0660, limit 5 → `done` after 1 generation, `done_code`=10, `gen_count`=1, `alive`=16'h0660.
- **Extinction**: pattern 16'h0001, limit 0 → `done_code`=01, `gen_count`=1, `alive`=0.
- **Oscillator, detect on**: pattern 16'h0070, macro defined → `done_code`=11, `gen_count`=2, `alive`=16'h0070.
- **Oscillator, detect off**: same pattern, macro undefined, limit 6 → `done_code`=00, `gen_count`=6.
- **Pulse spacing**: toad 16'h6186 with limit 4 → `write_enb` high exactly 1 cycle; `step` pulses exactly 4 cycles apart; `alive` alternates 16'h2664 / 16'h6186.
- **Abort and reset**: abort 1 cycle into WAIT of generation 3 → `busy` low next cycle, no further `step`, no `done`. Then `reset_n` low mid-run → all outputs zero in the same cycle.
